// File: rtl/led_pattern_seq_pkg.sv
// Shared encodings for the LED pattern sequencer.
// Mode and FSM constants plus the thermometer helper.
package led_pattern_seq_pkg;

    localparam int LEVEL_W = 8;

    localparam logic [1:0] MODE_BAR      = 2'd0;
    localparam logic [1:0] MODE_WALK     = 2'd1;
    localparam logic [1:0] MODE_PINGPONG = 2'd2;
    localparam logic [1:0] MODE_SOLID    = 2'd3;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    // Thermometer: top three level bits select how many low LEDs light.
    function automatic logic [LEVEL_W-1:0] bar_pattern(
        input logic [LEVEL_W-1:0] lvl
    );
        if (lvl == '0) return '0;
        return {LEVEL_W{1'b1}} >> (3'd7 - lvl[LEVEL_W-1 -: 3]);
    endfunction

endpackage

// File: rtl/ramp_turn_detect.sv
// Tracks ramp direction, flags peaks and troughs,
// and counts completed breaths (troughs) with saturation.
module ramp_turn_detect
    import led_pattern_seq_pkg::*;
(
    input  logic               clk_div,
    input  logic               rst,
    input  logic [LEVEL_W-1:0] level_in,
    output logic [LEVEL_W-1:0] level_q,
    output logic               peak_det,
    output logic               trough_det,
    output logic               peak_pulse,
    output logic               trough_pulse,
    output logic [7:0]         breath_cnt
);

    logic dir;

    assign peak_det   = dir && (level_in < level_q);
    assign trough_det = !dir && (level_in > level_q);

    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            level_q      <= '0;
            dir          <= 1'b1;
            peak_pulse   <= 1'b0;
            trough_pulse <= 1'b0;
            breath_cnt   <= '0;
        end else begin
            level_q      <= level_in;
            peak_pulse   <= peak_det;
            trough_pulse <= trough_det;
            if (level_in > level_q) begin
                dir <= 1'b1;
            end else if (level_in < level_q) begin
                dir <= 1'b0;
            end
            if (trough_det && breath_cnt != 8'hFF) begin
                breath_cnt <= breath_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: maps ramp level and breath events to
// one of four patterns; mode switches commit only at a trough.
module led_pattern_seq
    import led_pattern_seq_pkg::*;
#(
    parameter int STEP_PEAKS   = 1,
    parameter int SOLID_THRESH = 128
) (
    input  logic               clk_div,
    input  logic               rst,
    input  logic               enable,
    input  logic [LEVEL_W-1:0] level_in,
    input  logic [1:0]         mode_sel,
    input  logic               mode_req,
    output logic               mode_ack,
    output logic [1:0]         mode_cur,
    output logic [LEVEL_W-1:0] led_out,
    output logic               peak_pulse,
    output logic               trough_pulse,
    output logic [7:0]         breath_cnt
);

    localparam int         TW        = LEVEL_W + 1;
    localparam logic [3:0] STEP_LAST = 4'(STEP_PEAKS - 1);
    localparam logic [TW-1:0] THRESH = TW'(SOLID_THRESH);

    logic               state;
    logic               req_done;
    logic [2:0]         pos;
    logic               pp_up;
    logic [3:0]         step_cnt;
    logic [LEVEL_W-1:0] level_q;
    logic               peak_det;
    logic               trough_det;
    logic               accept;
    logic               walk_step;
    logic               pp_step;
    logic [LEVEL_W-1:0] pattern;

    ramp_turn_detect u_turn (
        .clk_div      (clk_div),
        .rst          (rst),
        .level_in     (level_in),
        .level_q      (level_q),
        .peak_det     (peak_det),
        .trough_det   (trough_det),
        .peak_pulse   (peak_pulse),
        .trough_pulse (trough_pulse),
        .breath_cnt   (breath_cnt)
    );

    // req_done blocks a second ack while the requester still holds req.
    assign accept = mode_req && !req_done &&
                    (state == ST_IDLE || trough_det);

    assign walk_step = (mode_cur == MODE_WALK) && peak_det;
    assign pp_step   = (mode_cur == MODE_PINGPONG) &&
                       (peak_det || trough_det);

    always_comb begin
        pattern = '0;
        unique case (mode_cur)
            MODE_BAR:      pattern = bar_pattern(level_q);
            MODE_WALK,
            MODE_PINGPONG: pattern = LEVEL_W'(1) << pos;
            MODE_SOLID:    pattern = ({1'b0, level_q} >= THRESH) ? '1 : '0;
            default:       pattern = '0;
        endcase
    end

    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            led_out  <= '0;
            mode_ack <= 1'b0;
            req_done <= 1'b0;
            mode_cur <= MODE_BAR;
        end else begin
            state    <= enable ? ST_RUN : ST_IDLE;
            led_out  <= (state == ST_RUN && enable) ? pattern : '0;
            mode_ack <= accept;
            if (!mode_req) begin
                req_done <= 1'b0;
            end else if (accept) begin
                req_done <= 1'b1;
            end
            if (accept) begin
                mode_cur <= mode_sel;
            end
        end
    end

    // A commit restarts the position; it wins over a coincident step.
    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            pos      <= '0;
            pp_up    <= 1'b1;
            step_cnt <= '0;
        end else if (accept) begin
            pos      <= '0;
            pp_up    <= 1'b1;
            step_cnt <= '0;
        end else if (walk_step) begin
            if (step_cnt == STEP_LAST) begin
                step_cnt <= '0;
                pos      <= pos + 3'd1;
            end else begin
                step_cnt <= step_cnt + 4'd1;
            end
        end else if (pp_step) begin
            if (pp_up) begin
                if (pos == 3'd7) begin
                    pos   <= 3'd6;
                    pp_up <= 1'b0;
                end else begin
                    pos <= pos + 3'd1;
                end
            end else begin
                if (pos == 3'd0) begin
                    pos   <= 3'd1;
                    pp_up <= 1'b1;
                end else begin
                    pos <= pos - 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Self-checking bench for led_pattern_seq against a
// sample-history reference model.
module tb_led_pattern_seq;

    localparam int STEP   = 2;
    localparam int THRESH = 128;
    localparam int AMP    = 20;

    logic       clk_div  = 1'b0;
    logic       rst      = 1'b0;
    logic       enable   = 1'b0;
    logic [7:0] level_in = 8'd0;
    logic [1:0] mode_sel = 2'd0;
    logic       mode_req = 1'b0;
    logic       mode_ack;
    logic [1:0] mode_cur;
    logic [7:0] led_out;
    logic       peak_pulse;
    logic       trough_pulse;
    logic [7:0] breath_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int ph     = 0;

    // reference model state
    int   m_hist[$];
    bit   m_run, m_done;
    int   m_mode, m_pk, m_ev, m_breath;
    logic [7:0] e_led, e_breath;
    logic [1:0] e_mode;
    logic       e_ack, e_pk, e_tr;

    led_pattern_seq #(
        .STEP_PEAKS   (STEP),
        .SOLID_THRESH (THRESH)
    ) dut (
        .clk_div      (clk_div),
        .rst          (rst),
        .enable       (enable),
        .level_in     (level_in),
        .mode_sel     (mode_sel),
        .mode_req     (mode_req),
        .mode_ack     (mode_ack),
        .mode_cur     (mode_cur),
        .led_out      (led_out),
        .peak_pulse   (peak_pulse),
        .trough_pulse (trough_pulse),
        .breath_cnt   (breath_cnt)
    );

    always #5 clk_div = ~clk_div;

    // Ramp direction = direction of the last strict change in history.
    function automatic bit m_rising();
        for (int i = m_hist.size() - 1; i > 0; i--) begin
            if (m_hist[i] != m_hist[i-1]) return m_hist[i] > m_hist[i-1];
        end
        return 1'b1;
    endfunction

    function automatic logic [7:0] m_pattern();
        int q;
        int k;
        q = m_hist[m_hist.size() - 1];
        k = m_ev % 14;
        case (m_mode)
            0: return (q == 0) ? 8'h00 : 8'((1 << (q / 32 + 1)) - 1);
            1: return 8'(1 << ((m_pk / STEP) % 8));
            2: return 8'(1 << ((k <= 7) ? k : 14 - k));
            default: return (q >= THRESH) ? 8'hFF : 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] tri_lvl(input int i);
        int p;
        p = i % (2 * AMP);
        return 8'((p < AMP) ? p + 1 : 2 * AMP - 1 - p);
    endfunction

    task automatic m_reset();
        m_hist.delete();
        m_hist.push_back(0);
        m_run = 0; m_done = 0;
        m_mode = 0; m_pk = 0; m_ev = 0; m_breath = 0;
        e_led = 0; e_breath = 0; e_mode = 0;
        e_ack = 0; e_pk = 0; e_tr = 0;
    endtask

    task automatic tick(input logic [7:0] lv);
        int q;
        bit r, pk, tr, acc;
        level_in = lv;
        @(posedge clk_div);
        q   = m_hist[m_hist.size() - 1];
        r   = m_rising();
        pk  = r && (int'(lv) < q);
        tr  = !r && (int'(lv) > q);
        acc = mode_req && !m_done && (!m_run || tr);
        e_led = (m_run && enable) ? m_pattern() : 8'h00;
        e_ack = acc; e_pk = pk; e_tr = tr;
        if (tr && m_breath < 255) m_breath++;
        e_breath = 8'(m_breath);
        if (acc) begin
            m_mode = int'(mode_sel); m_pk = 0; m_ev = 0;
        end else begin
            m_pk += int'(pk);
            m_ev += int'(pk || tr);
        end
        e_mode = 2'(m_mode);
        m_done = mode_req && (m_done || acc);
        m_run  = enable;
        m_hist.push_back(int'(lv));
        #1;
    endtask

    task automatic tri_tick();
        tick(tri_lvl(ph));
        ph++;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        m_reset();
        #2;
        n_chk++; if (led_out !== 8'h00) begin n_fail++; $display("FAIL reset_led got %h want 00", led_out); end
        n_chk++; if (mode_cur !== 2'd0) begin n_fail++; $display("FAIL reset_mode got %h want 0", mode_cur); end
        n_chk++; if (mode_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0", mode_ack); end
        n_chk++; if (peak_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_peak got %b want 0", peak_pulse); end
        n_chk++; if (trough_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_trough got %b want 0", trough_pulse); end
        n_chk++; if (breath_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_breath got %h want 00", breath_cnt); end
        @(posedge clk_div);
        #1 rst = 1'b0;
    endtask

    task automatic test_ramp();
        int npk, pk_lv;
        npk = 0; pk_lv = -1;
        enable = 1'b1;
        for (int v = 0; v <= 510; v++) begin
            int lv;
            lv = (v <= 255) ? v : 510 - v;
            tick(8'(lv));
            n_chk++; if (peak_pulse !== e_pk) begin n_fail++; $display("FAIL ramp_peak lv=%0d got %b want %b", lv, peak_pulse, e_pk); end
            if (peak_pulse === 1'b1) begin npk++; pk_lv = lv; end
        end
        n_chk++; if (npk != 1) begin n_fail++; $display("FAIL ramp_peak_count got %0d want 1", npk); end
        n_chk++; if (pk_lv != 254) begin n_fail++; $display("FAIL ramp_peak_at got %0d want 254", pk_lv); end
        n_chk++; if (breath_cnt !== 8'd0) begin n_fail++; $display("FAIL ramp_breath0 got %0d want 0", breath_cnt); end
        tick(8'd1);
        n_chk++; if (trough_pulse !== 1'b1) begin n_fail++; $display("FAIL ramp_trough got %b want 1", trough_pulse); end
        n_chk++; if (breath_cnt !== 8'd1) begin n_fail++; $display("FAIL ramp_breath1 got %0d want 1", breath_cnt); end
    endtask

    task automatic test_bar();
        logic [7:0] lvls [7];
        logic [7:0] want [7];
        lvls = '{8'd100, 8'd0, 8'd255, 8'd31, 8'd32, 8'd223, 8'd224};
        want = '{8'h0F, 8'h00, 8'hFF, 8'h01, 8'h03, 8'h7F, 8'hFF};
        for (int i = 0; i < 7; i++) begin
            tick(lvls[i]);
            tick(lvls[i]);
            n_chk++; if (led_out !== want[i]) begin n_fail++; $display("FAIL bar_led lv=%0d got %h want %h", lvls[i], led_out, want[i]); end
            n_chk++; if (led_out !== e_led) begin n_fail++; $display("FAIL bar_model lv=%0d got %h want %h", lvls[i], led_out, e_led); end
        end
    endtask

    task automatic test_mode_req();
        for (int v = 224; v >= 0; v -= 8) tick(8'(v));
        for (int v = 1; v <= 60; v++) begin
            if (v == 20) begin mode_sel = 2'd1; mode_req = 1'b1; end
            tick(8'(v));
            n_chk++; if (mode_ack !== 1'b0) begin n_fail++; $display("FAIL req_rise_ack lv=%0d got %b want 0", v, mode_ack); end
        end
        for (int v = 59; v >= 0; v--) begin
            tick(8'(v));
            n_chk++; if (mode_ack !== 1'b0) begin n_fail++; $display("FAIL req_fall_ack lv=%0d got %b want 0", v, mode_ack); end
        end
        tick(8'd1);
        n_chk++; if (mode_ack !== 1'b1) begin n_fail++; $display("FAIL req_ack got %b want 1", mode_ack); end
        n_chk++; if (trough_pulse !== 1'b1) begin n_fail++; $display("FAIL req_trough got %b want 1", trough_pulse); end
        n_chk++; if (mode_cur !== 2'd1) begin n_fail++; $display("FAIL req_mode got %0d want 1", mode_cur); end
        mode_req = 1'b0;
        tick(8'd2);
        n_chk++; if (led_out !== 8'h01) begin n_fail++; $display("FAIL req_walk_led got %h want 01", led_out); end
        n_chk++; if (mode_ack !== 1'b0) begin n_fail++; $display("FAIL req_ack_once got %b want 0", mode_ack); end
        ph = 2;
    endtask

    task automatic test_walk();
        int npk;
        bit saw80;
        npk = 0; saw80 = 0;
        for (int n = 0; n < 16 * 2 * AMP; n++) begin
            tri_tick();
            n_chk++; if (led_out !== e_led) begin n_fail++; $display("FAIL walk_led n=%0d got %h want %h", n, led_out, e_led); end
            if (peak_pulse === 1'b1) npk++;
            if (led_out === 8'h80) saw80 = 1;
        end
        n_chk++; if (npk != 16) begin n_fail++; $display("FAIL walk_peaks got %0d want 16", npk); end
        n_chk++; if (!saw80) begin n_fail++; $display("FAIL walk_reach80 got 0 want 1"); end
        n_chk++; if (led_out !== 8'h01) begin n_fail++; $display("FAIL walk_wrap got %h want 01", led_out); end
    endtask

    task automatic test_pingpong();
        logic [7:0] seq[$];
        bit got_ack;
        got_ack = 0;
        mode_sel = 2'd2; mode_req = 1'b1;
        for (int n = 0; n < 2 * AMP + 16 * AMP + 10; n++) begin
            tri_tick();
            n_chk++; if (led_out !== e_led) begin n_fail++; $display("FAIL pp_led n=%0d got %h want %h", n, led_out, e_led); end
            if (got_ack) begin
                if (seq.size() == 0 || seq[seq.size() - 1] !== led_out) seq.push_back(led_out);
            end
            if (mode_ack === 1'b1) begin got_ack = 1; mode_req = 1'b0; end
        end
        mode_req = 1'b0;
        n_chk++; if (!got_ack) begin n_fail++; $display("FAIL pp_ack got 0 want 1"); end
        n_chk++; if (seq.size() < 15) begin n_fail++; $display("FAIL pp_len got %0d want >=15", seq.size()); end
        for (int j = 0; j < 15 && j < seq.size(); j++) begin
            logic [7:0] w;
            w = 8'(1 << ((j <= 7) ? j : 14 - j));
            n_chk++; if (seq[j] !== w) begin n_fail++; $display("FAIL pp_seq j=%0d got %h want %h", j, seq[j], w); end
        end
    endtask

    task automatic test_idle();
        bit got_ack;
        got_ack = 0;
        mode_sel = 2'd1; mode_req = 1'b1;
        for (int n = 0; n < 3 * AMP && !got_ack; n++) begin
            tri_tick();
            if (mode_ack === 1'b1) got_ack = 1;
        end
        mode_req = 1'b0;
        n_chk++; if (!got_ack) begin n_fail++; $display("FAIL idle_walk_ack got 0 want 1"); end
        for (int n = 0; n < 5; n++) tri_tick();
        n_chk++; if (led_out !== 8'h01) begin n_fail++; $display("FAIL idle_walk_led got %h want 01", led_out); end
        enable = 1'b0;
        tri_tick();
        n_chk++; if (led_out !== 8'h00) begin n_fail++; $display("FAIL idle_led_off got %h want 00", led_out); end
        n_chk++; if (led_out !== e_led) begin n_fail++; $display("FAIL idle_led_model got %h want %h", led_out, e_led); end
        mode_sel = 2'd3; mode_req = 1'b1;
        tri_tick();
        n_chk++; if (mode_ack !== 1'b1) begin n_fail++; $display("FAIL idle_ack got %b want 1", mode_ack); end
        n_chk++; if (mode_cur !== 2'd3) begin n_fail++; $display("FAIL idle_mode got %0d want 3", mode_cur); end
        mode_req = 1'b0;
        tri_tick();
        n_chk++; if (mode_ack !== 1'b0) begin n_fail++; $display("FAIL idle_ack_once got %b want 0", mode_ack); end
    endtask

    task automatic test_solid();
        enable = 1'b1;
        repeat (3) tick(8'd128);
        n_chk++; if (led_out !== 8'hFF) begin n_fail++; $display("FAIL solid_on got %h want FF", led_out); end
        repeat (3) tick(8'd127);
        n_chk++; if (led_out !== 8'h00) begin n_fail++; $display("FAIL solid_off got %h want 00", led_out); end
        n_chk++; if (led_out !== e_led) begin n_fail++; $display("FAIL solid_model got %h want %h", led_out, e_led); end
    endtask

    task automatic test_reset_mid_req();
        mode_sel = 2'd2; mode_req = 1'b1;
        for (int v = 120; v >= 100; v -= 5) begin
            tick(8'(v));
            n_chk++; if (mode_ack !== 1'b0) begin n_fail++; $display("FAIL rstreq_ack lv=%0d got %b want 0", v, mode_ack); end
        end
        rst = 1'b1;
        mode_req = 1'b0;
        m_reset();
        #2;
        n_chk++; if (mode_cur !== 2'd0) begin n_fail++; $display("FAIL rstreq_mode got %0d want 0", mode_cur); end
        @(posedge clk_div);
        #1 rst = 1'b0;
        repeat (3) begin
            tick(8'd0);
            n_chk++; if (mode_ack !== 1'b0) begin n_fail++; $display("FAIL rstreq_noack got %b want 0", mode_ack); end
        end
        n_chk++; if (mode_cur !== 2'd0) begin n_fail++; $display("FAIL rstreq_mode_after got %0d want 0", mode_cur); end
    endtask

    task automatic test_random();
        int lvl, d, stp;
        lvl = 0; d = 1;
        for (int n = 0; n < 2500; n++) begin
            if ($urandom % 50 == 0) enable = ~enable;
            if (!mode_req && $urandom % 15 == 0) begin
                mode_sel = 2'($urandom % 4);
                mode_req = 1'b1;
            end else if (mode_req && $urandom % 80 == 0) begin
                mode_req = 1'b0;
            end
            stp = $urandom % 4;
            if ($urandom % 25 == 0) d = -d;
            lvl += d * stp;
            if (lvl > 255) begin lvl = 255; d = -1; end
            if (lvl < 0) begin lvl = 0; d = 1; end
            tick(8'(lvl));
            n_chk++; if (led_out !== e_led) begin n_fail++; $display("FAIL rnd_led n=%0d got %h want %h", n, led_out, e_led); end
            n_chk++; if (mode_cur !== e_mode) begin n_fail++; $display("FAIL rnd_mode n=%0d got %0d want %0d", n, mode_cur, e_mode); end
            n_chk++; if (mode_ack !== e_ack) begin n_fail++; $display("FAIL rnd_ack n=%0d got %b want %b", n, mode_ack, e_ack); end
            n_chk++; if (peak_pulse !== e_pk) begin n_fail++; $display("FAIL rnd_peak n=%0d got %b want %b", n, peak_pulse, e_pk); end
            n_chk++; if (trough_pulse !== e_tr) begin n_fail++; $display("FAIL rnd_trough n=%0d got %b want %b", n, trough_pulse, e_tr); end
            n_chk++; if (breath_cnt !== e_breath) begin n_fail++; $display("FAIL rnd_breath n=%0d got %0d want %0d", n, breath_cnt, e_breath); end
            if (mode_ack === 1'b1) mode_req = 1'b0;
        end
        mode_req = 1'b0;
    endtask

    task automatic test_saturate();
        for (int n = 0; n < 600; n++) begin
            tick(8'(n % 2));
            n_chk++; if (breath_cnt !== e_breath) begin n_fail++; $display("FAIL sat_model n=%0d got %0d want %0d", n, breath_cnt, e_breath); end
        end
        n_chk++; if (breath_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_hold got %0d want 255", breath_cnt); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_bar();
        test_mode_req();
        test_walk();
        test_pingpong();
        test_idle();
        test_solid();
        test_reset_mid_req();
        test_random();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/led_pattern_seq.md
# led_pattern_seq

Pattern sequencer that sits directly downstream of the brightness ramp generator. It consumes the 8-bit triangle-ramp level, detects its turning points (peaks and troughs), and counts completed breaths. It maps the level and the breath events onto one of four LED display patterns. Mode changes use a req/ack handshake that is committed only at a trough, so patterns never switch mid-breath.

## Interface
Parameters:
- `STEP_PEAKS`, default 1: number of peak events per WALK position step (1..15).
- `SOLID_THRESH`, default 128: level at or above which SOLID mode lights all LEDs.

Ports:
- `clk_div`, in, 1: ramp-rate clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `enable`, in, 1: run/idle control.
- `level_in`, in, 8: ramp level from the upstream generator; one new sample per clock.
- `mode_sel`, in, 2: requested mode. 0 = BAR, 1 = WALK, 2 = PINGPONG, 3 = SOLID.
- `mode_req`, in, 1: mode change request. Held high with `mode_sel` stable until ack.
- `mode_ack`, out, 1: single-cycle pulse when the requested mode is committed.
- `mode_cur`, out, 2: currently active mode.
- `led_out`, out, 8: LED drive pattern.
- `peak_pulse`, out, 1: one-cycle pulse on a rising→falling turn.
- `trough_pulse`, out, 1: one-cycle pulse on a falling→rising turn.
- `breath_cnt`, out, 8: count of troughs since reset. Saturates at 255.

## Operation
- Sampling:
  - `level_q` <= `level_in` every cycle.
  - Direction register `dir`: 1 = rising, 0 = falling.
  - `level_in > level_q` sets `dir` to 1; `<` clears it; `==` holds it.
- Events:
  - peak = `dir==1` and `level_in < level_q`.
  - trough = `dir==0` and `level_in > level_q`.
  - Peak and trough are mutually exclusive by construction.
- Top FSM has states IDLE and RUN.
  - IDLE→RUN when `enable` is high.
  - RUN→IDLE immediately when `enable` is low.
  - In IDLE, `led_out` = 0. Events and `breath_cnt` keep running.
- Mode handshake:
  - In IDLE, a pending `mode_req` is accepted the next cycle.
  - In RUN, `mode_req` is accepted only in the cycle a trough is detected.
  - On accept: `mode_cur` <= `mode_sel`, `mode_ack` = 1 for one cycle, and the WALK/PINGPONG position and step counter reset to 0.
  - `mode_req` low before ack withdraws the request; no ack is issued.
  - Requesting the current mode is still acked.
- Patterns, all derived from `level_q`:
  - BAR: thermometer. `led_out` = 0 if `level_q` == 0; otherwise the low (`level_q[7:5]`+1) bits are set. Levels 1..31 light 1 LED; 224..255 light 8.
  - WALK: one-hot at `pos`. `pos` advances +1 every `STEP_PEAKS` peaks and wraps 7→0.
  - PINGPONG: one-hot at `pos`. `pos` moves one step on every peak and on every trough, bouncing 0→7→0. At 7 the next step goes to 6; at 0 it goes to 1.
  - SOLID: 8'hFF if `level_q >= SOLID_THRESH`, else 0.
- `breath_cnt` increments on each trough and holds at 255.

## Timing
- Reset values:
  - `led_out` = 0, `mode_cur` = 0 (BAR), `mode_ack` = 0, `peak_pulse` = 0, `trough_pulse` = 0, `breath_cnt` = 0.
  - `level_q` = 0, `dir` = 1, `pos` = 0, step counter = 0, FSM = IDLE.
- All outputs are registered.
- Latencies:
  - `peak_pulse`/`trough_pulse` assert in the cycle after the turning sample is on `level_in`.
  - `mode_ack` asserts in the same cycle as `trough_pulse`.
  - The new mode's pattern appears on `led_out` one cycle after `mode_ack`.
  - BAR/SOLID `led_out` lags `level_in` by 2 cycles.
- Reset mid-operation: every register returns to its reset value at once, and any pending request is dropped (not acked).
- An ack coinciding with a WALK/PINGPONG step: the reset of `pos` wins.

## Structure
- Shared package holds the mode encodings (`MODE_BAR`, `MODE_WALK`, `MODE_PINGPONG`, `MODE_SOLID`), the FSM state encodings, and the 8-bit level width constant.
- One sub-module, `ramp_turn_detect`: owns `level_q`, `dir`, the peak/trough pulses and `breath_cnt`. The pattern FSM and handshake live in the top module.

## Test plan
- Reset, then `enable` = 1, `level_in` ramps 0→255→0 by 1 per cycle: `peak_pulse` fires exactly once, 1 cycle after `level_in` = 254 (first falling sample). At end of the ramp, `breath_cnt` = 0. A following rise from 0 to 1 gives `trough_pulse` and `breath_cnt` = 1.
- BAR mode, constant `level_in` = 100: `led_out` = 8'h0F after 2 cycles. `level_in` = 0 gives 8'h00; 255 gives 8'hFF.
- `mode_req` = 1 with `mode_sel` = 1 mid-rise: no ack until the next trough. Then `mode_ack` pulses together with `trough_pulse`, `mode_cur` = 1, and `led_out` = 8'h01 the next cycle.
- WALK with `STEP_PEAKS` = 2, 16 full breaths: `pos` wraps, and `led_out` returns to 8'h01 after 16 peaks.
- PINGPONG over 8 breaths: the `led_out` sequence is 01, 02, 04, …, 80, 40, … — reverses at 8'h80 and at 8'h01.
- `enable` dropped in WALK: `led_out` = 0 the next cycle. A pending request is acked immediately in IDLE. Asserting `rst` mid-request: no ack, and `mode_cur` = 0.
